// File: rtl/cnt_credit_tracker.sv
// Purpose: turns increments of a synchronised event count into poppable credits, measures window rate, flags jumps/overflow.
// Latency: avail/credit_vld/error flags update one cycle after cnt_in or pop_req; rate_vld pulses the cycle after the last window sample.
// Backpressure: pop_req is honoured only while credit_vld is high; credits saturate at 2^DW-1 instead of wrapping.
module cnt_credit_tracker #(
  parameter  int DW       = 8,
  parameter  int WIN      = 256,
  parameter  int MAX_STEP = 4,
  localparam int RW       = DW + $clog2(WIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] cnt_in,
  input  logic          en,
  input  logic          pop_req,
  input  logic          clr_err,
  output logic          credit_vld,
  output logic [DW-1:0] avail,
  output logic [RW-1:0] rate,
  output logic          rate_vld,
  output logic          err_jump,
  output logic          err_ovf
);

  localparam int WCW = $clog2(WIN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   cnt_q;
  logic [DW-1:0]   step;
  logic            pop;
  logic [DW:0]     next_sum;
  logic            jump;
  logic [WCW-1:0]  win_cnt;
  logic [WCW-1:0]  win_cnt_nxt;
  logic [RW-1:0]   acc;
  logic [RW-1:0]   acc_nxt;
  logic [RW-1:0]   rate_sum;
  logic            rate_ld;

  // Modulo subtraction makes the 2^DW-1 -> 0 wrap count as a single step.
  assign step       = cnt_in - cnt_q;
  assign credit_vld = (avail != '0);
  assign pop        = pop_req & credit_vld;
  // One extra bit so an arrival that would wrap the credit count is detectable.
  assign next_sum   = {1'b0, avail} + {1'b0, step} - (DW+1)'(pop);
  assign jump       = (step > DW'(MAX_STEP));
  assign rate_sum   = acc + RW'(step);

  // Previous count sample and credit counter with saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      avail <= '0;
    end else begin
      cnt_q <= cnt_in;
      if (next_sum[DW]) avail <= '1;
      else              avail <= next_sum[DW-1:0];
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_jump <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      err_jump <= jump        | (err_jump & ~clr_err);
      err_ovf  <= next_sum[DW] | (err_ovf & ~clr_err);
    end
  end

  // Window FSM state, window counter, accumulator and rate output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      win_cnt  <= '0;
      acc      <= '0;
      rate     <= '0;
      rate_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      win_cnt  <= win_cnt_nxt;
      acc      <= acc_nxt;
      rate_vld <= rate_ld;
      if (rate_ld) rate <= rate_sum;
    end
  end

  // Next-state logic: dropping en discards a partial window without publishing it.
  always_comb begin
    state_nxt   = state;
    win_cnt_nxt = win_cnt;
    acc_nxt     = acc;
    rate_ld     = 1'b0;
    case (state)
      IDLE: begin
        win_cnt_nxt = '0;
        acc_nxt     = '0;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en) begin
          state_nxt   = IDLE;
          win_cnt_nxt = '0;
          acc_nxt     = '0;
        end else if (win_cnt == WCW'(WIN-1)) begin
          win_cnt_nxt = '0;
          acc_nxt     = '0;
          rate_ld     = 1'b1;
        end else begin
          win_cnt_nxt = win_cnt + 1'b1;
          acc_nxt     = rate_sum;
        end
      end
      default: begin
        state_nxt   = IDLE;
        win_cnt_nxt = '0;
        acc_nxt     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cnt_credit_tracker.sv
// Bench for cnt_credit_tracker with WIN=8, DW=8, MAX_STEP=4.
// Expected values come from constant tables pushed into scoreboard queues.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_cnt_credit_tracker;

  localparam int DW  = 8;
  localparam int WIN = 8;
  localparam int RW  = DW + $clog2(WIN);

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] cnt_in;
  logic          en;
  logic          pop_req;
  logic          clr_err;
  logic          credit_vld;
  logic [DW-1:0] avail;
  logic [RW-1:0] rate;
  logic          rate_vld;
  logic          err_jump;
  logic          err_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] cnt;
  logic [DW-1:0] exp_avail_q[$];
  logic [RW-1:0] exp_rate_q[$];

  cnt_credit_tracker #(.DW(DW), .WIN(WIN), .MAX_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .en(en), .pop_req(pop_req),
    .clr_err(clr_err), .credit_vld(credit_vld), .avail(avail), .rate(rate),
    .rate_vld(rate_vld), .err_jump(err_jump), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({credit_vld, avail, rate, rate_vld, err_jump, err_ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b avail=%0d rate=%0d rvld=%b ej=%b eo=%b, expected all 0",
               credit_vld, avail, rate, rate_vld, err_jump, err_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (credit_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_credit_vld: got %b expected 0", credit_vld);
    end
  endtask

  task automatic test_count();
    logic [DW-1:0] e;
    for (int k = 1; k <= 3; k++) begin
      cnt = DW'(k);
      cnt_in = cnt;
      exp_avail_q.push_back(DW'(k));
      tick();
      e = exp_avail_q.pop_front();
      n_checks++;
      if (avail !== e) begin
        n_fail++;
        $display("FAIL count_avail[%0d]: got %0d expected %0d", k, avail, e);
      end
      n_checks++;
      if (credit_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL count_credit_vld[%0d]: got %b expected 1", k, credit_vld);
      end
    end
  endtask

  task automatic test_pop();
    int d[5]  = '{0, 1, 0, 0, 0};
    int ex[5] = '{2, 2, 1, 0, 0};
    logic [DW-1:0] e;
    for (int k = 0; k < 5; k++) begin
      cnt = cnt + DW'(d[k]);
      cnt_in = cnt;
      pop_req = 1'b1;
      exp_avail_q.push_back(DW'(ex[k]));
      tick();
      e = exp_avail_q.pop_front();
      n_checks++;
      if (avail !== e) begin
        n_fail++;
        $display("FAIL pop_avail[%0d]: got %0d expected %0d", k, avail, e);
      end
    end
    pop_req = 1'b0;
    n_checks++;
    if (credit_vld !== 1'b0 || err_ovf !== 1'b0 || err_jump !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_empty: got vld=%b eo=%b ej=%b expected 0 0 0", credit_vld, err_ovf, err_jump);
    end
  endtask

  task automatic test_jump();
    int c[4]  = '{10, 10, 20, 20};
    int cl[4] = '{0, 1, 1, 1};
    int ea[4] = '{6, 6, 16, 16};
    int ej[4] = '{1, 0, 1, 0};
    logic [DW-1:0] e;
    for (int k = 0; k < 4; k++) begin
      cnt = DW'(c[k]);
      cnt_in = cnt;
      clr_err = cl[k][0];
      exp_avail_q.push_back(DW'(ea[k]));
      tick();
      e = exp_avail_q.pop_front();
      n_checks++;
      if (avail !== e) begin
        n_fail++;
        $display("FAIL jump_avail[%0d]: got %0d expected %0d", k, avail, e);
      end
      n_checks++;
      if (err_jump !== ej[k][0]) begin
        n_fail++;
        $display("FAIL jump_flag[%0d]: got %b expected %0d", k, err_jump, ej[k]);
      end
    end
    clr_err = 1'b0;
  endtask

  task automatic test_wrap();
    int c[5]  = '{254, 254, 255, 0, 1};
    int cl[5] = '{0, 1, 0, 0, 0};
    int ea[5] = '{250, 250, 251, 252, 253};
    int ej[5] = '{1, 0, 0, 0, 0};
    logic [DW-1:0] e;
    for (int k = 0; k < 5; k++) begin
      cnt = DW'(c[k]);
      cnt_in = cnt;
      clr_err = cl[k][0];
      exp_avail_q.push_back(DW'(ea[k]));
      tick();
      e = exp_avail_q.pop_front();
      n_checks++;
      if (avail !== e) begin
        n_fail++;
        $display("FAIL wrap_avail[%0d]: got %0d expected %0d", k, avail, e);
      end
      n_checks++;
      if (err_jump !== ej[k][0]) begin
        n_fail++;
        $display("FAIL wrap_jump[%0d]: got %b expected %0d", k, err_jump, ej[k]);
      end
    end
    clr_err = 1'b0;
  endtask

  task automatic test_overflow();
    int c[4]  = '{2, 5, 5, 5};
    int cl[4] = '{0, 0, 0, 1};
    int ea[4] = '{254, 255, 255, 255};
    int eo[4] = '{0, 1, 1, 0};
    logic [DW-1:0] e;
    for (int k = 0; k < 4; k++) begin
      cnt = DW'(c[k]);
      cnt_in = cnt;
      clr_err = cl[k][0];
      exp_avail_q.push_back(DW'(ea[k]));
      tick();
      e = exp_avail_q.pop_front();
      n_checks++;
      if (avail !== e) begin
        n_fail++;
        $display("FAIL ovf_avail[%0d]: got %0d expected %0d", k, avail, e);
      end
      n_checks++;
      if (err_ovf !== eo[k][0]) begin
        n_fail++;
        $display("FAIL ovf_flag[%0d]: got %b expected %0d", k, err_ovf, eo[k]);
      end
    end
    clr_err = 1'b0;
  endtask

  // Runs n cycles of +1 arrivals with pop_req held; a pulse is expected after
  // every 8th RUN sample counting from the cycle en was first sampled.
  task automatic run_window(input string tag, input int n, input int first_pulse);
    logic          exp_p;
    logic [RW-1:0] er;
    for (int i = 0; i < n; i++) begin
      cnt = cnt + 1'b1;
      cnt_in = cnt;
      pop_req = 1'b1;
      en = 1'b1;
      exp_p = (i >= first_pulse) && ((i % WIN) == 0);
      if (exp_p) exp_rate_q.push_back(RW'(WIN));
      tick();
      n_checks++;
      if (rate_vld !== exp_p) begin
        n_fail++;
        $display("FAIL %s_rate_vld[%0d]: got %b expected %b", tag, i, rate_vld, exp_p);
      end
      if (exp_p) begin
        er = exp_rate_q.pop_front();
        n_checks++;
        if (rate !== er) begin
          n_fail++;
          $display("FAIL %s_rate[%0d]: got %0d expected %0d", tag, i, rate, er);
        end
      end
    end
  endtask

  task automatic test_window();
    run_window("win", 28, WIN);
    n_checks++;
    if (avail !== 8'd255 || err_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL win_avail_hold: got avail=%0d eo=%b expected 255 0", avail, err_ovf);
    end
    for (int i = 0; i < 10; i++) begin
      cnt = cnt + 1'b1;
      cnt_in = cnt;
      en = 1'b0;
      tick();
      n_checks++;
      if (rate_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL win_idle_rate_vld[%0d]: got %b expected 0", i, rate_vld);
      end
    end
    n_checks++;
    if (rate !== RW'(WIN)) begin
      n_fail++;
      $display("FAIL win_rate_hold: got %0d expected %0d", rate, WIN);
    end
    run_window("rewin", 9, WIN);
  endtask

  task automatic test_reset_mid();
    pop_req = 1'b0;
    cnt = cnt + 1'b1;
    cnt_in = cnt;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({credit_vld, avail, rate, rate_vld, err_jump, err_ovf} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got vld=%b avail=%0d rate=%0d rvld=%b ej=%b eo=%b, expected all 0",
               credit_vld, avail, rate, rate_vld, err_jump, err_ovf);
    end
    en = 1'b0;
    cnt = 8'd3;
    cnt_in = cnt;
    @(negedge clk);
    rst_n = 1'b1;
    exp_avail_q.push_back(8'd3);
    tick();
    n_checks++;
    if (avail !== exp_avail_q.pop_front() || credit_vld !== 1'b1 || err_jump !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_first_step: got avail=%0d vld=%b ej=%b expected 3 1 0", avail, credit_vld, err_jump);
    end
    run_window("postrst", 9, WIN);
  endtask

  initial begin
    rst_n   = 1'b0;
    cnt     = '0;
    cnt_in  = '0;
    en      = 1'b0;
    pop_req = 1'b0;
    clr_err = 1'b0;
    test_reset();
    test_count();
    test_pop();
    test_jump();
    test_wrap();
    test_overflow();
    test_window();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
